// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: decodes ALUOp/Function, runs 1-cycle ops in EXEC and shift-add mult / restoring div in ITER.
// Optional divider hardware is built only when ALU_SEQ_DIVIDE_EN is defined.
//
// state | meaning
// IDLE  | waiting for Start, Ready=1
// EXEC  | single-cycle op (add/sub/and/or, div-by-zero, div without divider)
// ITER  | one mult/div step per clock, counter runs WIDTH..1
// DONE  | one-cycle Done pulse, results valid
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Abort,
    input  logic [1:0]       ALUOp,
    input  logic [3:0]       Function,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Ready,
    output logic             Busy,
    output logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       code_q, code_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             dbz_q, dbz_d;
    // Working accumulator kept apart from Result so an abort leaves old results intact.
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;

    logic [2:0]       dec_code;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH:0]   mul_sum;

    function automatic logic [2:0] decode(input logic [1:0] op, input logic [3:0] fn);
        logic [2:0] c;
        c = OP_ADD;
        case (op)
            2'b10: c = OP_AND;
            2'b11: c = OP_OR;
            2'b00: begin
                case (fn)
                    4'b0000: c = OP_ADD;
                    4'b0001: c = OP_SUB;
                    4'b0100: c = OP_MUL;
                    4'b0101: c = OP_DIV;
                    default: c = OP_ADD;
                endcase
            end
            default: c = OP_ADD;
        endcase
        return c;
    endfunction

    assign dec_code = decode(ALUOp, Function);

    // Multiplier in acc_lo shifts out LSB-first while partial sums shift into acc_hi.
    assign mul_sum = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? a_q : {WIDTH{1'b0}})};

`ifdef ALU_SEQ_DIVIDE_EN
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_trial;
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, b_q};
`endif

    always_comb begin
        step_hi = {mul_sum[WIDTH:1]};
        step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIVIDE_EN
        // Remainder in acc_hi, dividend shifts out of acc_lo as quotient bits shift in.
        if (code_q == OP_DIV) begin
            if (!div_trial[WIDTH]) begin
                step_hi = div_trial[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        code_d   = code_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        dbz_d    = dbz_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    code_d = dec_code;
                    a_d    = A;
                    b_d    = B;
                    dbz_d  = 1'b0;
                    if (dec_code == OP_MUL) begin
                        state_d  = S_ITER;
                        cnt_d    = CW'(WIDTH);
                        acc_hi_d = '0;
                        acc_lo_d = B;
`ifdef ALU_SEQ_DIVIDE_EN
                    end else if (dec_code == OP_DIV && B != '0) begin
                        state_d  = S_ITER;
                        cnt_d    = CW'(WIDTH);
                        acc_hi_d = '0;
                        acc_lo_d = A;
`endif
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (Abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                    res_hi_d = '0;
                    case (code_q)
                        OP_ADD:  res_d = a_q + b_q;
                        OP_SUB:  res_d = a_q - b_q;
                        OP_AND:  res_d = a_q & b_q;
                        OP_OR:   res_d = a_q | b_q;
`ifdef ALU_SEQ_DIVIDE_EN
                        OP_DIV: begin
                            res_d    = '1;
                            res_hi_d = a_q;
                            dbz_d    = 1'b1;
                        end
`endif
                        default: res_d = '0;
                    endcase
                end
            end
            S_ITER: begin
                if (Abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    if (cnt_q == CW'(1)) begin
                        state_d  = S_DONE;
                        res_d    = step_lo;
                        res_hi_d = step_hi;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            code_q   <= OP_ADD;
            res_q    <= '0;
            res_hi_q <= '0;
            dbz_q    <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            code_q   <= code_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            dbz_q    <= dbz_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
        end
    end

    assign Ready      = (state_q == S_IDLE);
    assign Busy       = (state_q == S_EXEC) || (state_q == S_ITER);
    assign Done       = (state_q == S_DONE);
    assign ALUControl = code_q;
    assign Result     = res_q;
    assign ResultHi   = res_hi_q;
    assign DivByZero  = dbz_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed spec scenarios plus random ops against an arithmetic model.
module tb_alu_sequencer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         Start = 1'b0;
    logic         Abort = 1'b0;
    logic [1:0]   ALUOp = '0;
    logic [3:0]   Function = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Ready, Busy, Done, DivByZero;
    logic [2:0]   ALUControl;
    logic [W-1:0] Result, ResultHi;

    int n_cmp = 0;
    int n_err = 0;

    alu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Abort(Abort),
        .ALUOp(ALUOp), .Function(Function), .A(A), .B(B),
        .Ready(Ready), .Busy(Busy), .ALUControl(ALUControl),
        .Result(Result), .ResultHi(ResultHi), .Done(Done), .DivByZero(DivByZero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [1:0] op, input logic [3:0] fn,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [2:0] code, output logic [W-1:0] r,
                                  output logic [W-1:0] rh, output logic dz, output int lat);
        logic [2*W-1:0] p;
        if (op == 2'b10) code = 3'd4;
        else if (op == 2'b11) code = 3'd5;
        else if (op == 2'b00 && fn == 4'd1) code = 3'd1;
        else if (op == 2'b00 && fn == 4'd4) code = 3'd2;
        else if (op == 2'b00 && fn == 4'd5) code = 3'd3;
        else code = 3'd0;
        rh = '0; dz = 1'b0; lat = 1; r = '0;
        case (code)
            3'd0: r = W'((int'(a) + int'(b)) % (1 << W));
            3'd1: r = W'((int'(a) - int'(b) + (1 << W)) % (1 << W));
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd2: begin
                p = (2*W)'(a) * (2*W)'(b);
                r = p[W-1:0]; rh = p[2*W-1:W]; lat = W;
            end
            default: begin
`ifdef ALU_SEQ_DIVIDE_EN
                if (b == 0) begin
                    r = '1; rh = a; dz = 1'b1;
                end else begin
                    r = a / b; rh = a % b; lat = W;
                end
`endif
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [3:0] fn,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke, input bit with_abort, input string name);
        logic [2:0] ec; logic [W-1:0] er, erh; logic edz; int elat; int n;
        model(op, fn, a, b, ec, er, erh, edz, elat);
        n = 0;
        while (Ready !== 1'b1 && n < 60) begin tick(); n++; end
        n_cmp++;
        if (Ready !== 1'b1) begin
            n_err++; $display("FAIL %s ready_timeout: Ready=%b required 1", name, Ready); return;
        end
        ALUOp = op; Function = fn; A = a; B = b; Start = 1'b1; Abort = with_abort;
        tick();
        Start = 1'b0; Abort = 1'b0;
        n = 0;
        while (n < W + 10) begin
            if (poke && n == 3) begin Start = 1'b1; ALUOp = 2'b10; A = ~a; end
            if (poke && n == 5) Start = 1'b0;
            tick(); n++;
            if (Done === 1'b1) break;
        end
        Start = 1'b0;
        n_cmp++;
        if (Done !== 1'b1 || n != elat) begin
            n_err++; $display("FAIL %s latency: got %0d (Done=%b) required %0d", name, n, Done, elat);
        end
        n_cmp++;
        if (Result !== er) begin n_err++; $display("FAIL %s result: got %h required %h", name, Result, er); end
        n_cmp++;
        if (ResultHi !== erh) begin n_err++; $display("FAIL %s result_hi: got %h required %h", name, ResultHi, erh); end
        n_cmp++;
        if (ALUControl !== ec) begin n_err++; $display("FAIL %s alucontrol: got %b required %b", name, ALUControl, ec); end
        n_cmp++;
        if (DivByZero !== edz) begin n_err++; $display("FAIL %s divbyzero: got %b required %b", name, DivByZero, edz); end
        tick();
        n_cmp++;
        if (Done !== 1'b0 || Ready !== 1'b1 || Result !== er || ResultHi !== erh) begin
            n_err++;
            $display("FAIL %s after_done: Done=%b Ready=%b Result=%h ResultHi=%h required 0 1 %h %h",
                     name, Done, Ready, Result, ResultHi, er, erh);
        end
        if (poke) begin
            tick(); tick();
            n_cmp++;
            if (Busy !== 1'b0 || Ready !== 1'b1) begin
                n_err++; $display("FAIL %s start_ignored: Busy=%b Ready=%b required 0 1", name, Busy, Ready);
            end
        end
    endtask

    task automatic check_reset_vals(input string name);
        n_cmp++;
        if (Ready !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0 || ALUControl !== 3'b000 ||
            Result !== '0 || ResultHi !== '0 || DivByZero !== 1'b0) begin
            n_err++;
            $display("FAIL %s: Ready=%b Busy=%b Done=%b Ctl=%b R=%h RH=%h DZ=%b required 1 0 0 000 0 0 0",
                     name, Ready, Busy, Done, ALUControl, Result, ResultHi, DivByZero);
        end
    endtask

    task automatic test_reset();
        int seen;
        #3 check_reset_vals("reset_initial");
        @(negedge clk) rst_n = 1'b1;
        run_op(2'b00, 4'b0000, 16'h1234, 16'h0FFF, 0, 0, "pre_reset_add");
        ALUOp = 2'b00; Function = 4'b0100; A = 16'h0123; B = 16'h0456; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (11) tick();
        #2 rst_n = 1'b0;
        #1 check_reset_vals("reset_mid_mult");
        @(negedge clk) rst_n = 1'b1;
        tick();
        n_cmp++;
        if (Ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b required 1", Ready); end
        seen = 0;
        repeat (W + 4) begin tick(); if (Done === 1'b1) seen++; end
        n_cmp++;
        if (seen != 0) begin n_err++; $display("FAIL reset_no_done: got %0d Done pulses required 0", seen); end
    endtask

    task automatic test_back_to_back();
        run_op(2'b00, 4'b0000, 16'h1234, 16'h0FFF, 0, 0, "add");
        run_op(2'b11, 4'b1010, 16'h00F0, 16'h0F00, 0, 0, "or_b2b");
        run_op(2'b10, 4'b0110, 16'hF0F3, 16'h3C3F, 0, 0, "and");
    endtask

    task automatic test_sub_decode();
        run_op(2'b00, 4'b0001, 16'h0000, 16'h0001, 0, 0, "sub_wrap");
        run_op(2'b01, 4'b0011, 16'h8000, 16'h8001, 0, 0, "undef_enc_add");
        run_op(2'b00, 4'b1111, 16'hFFFF, 16'h0002, 0, 0, "undef_fn_add");
    endtask

    task automatic test_mult();
        run_op(2'b00, 4'b0100, 16'h0100, 16'h0300, 1, 0, "mult");
        run_op(2'b00, 4'b0100, 16'hFFFF, 16'hFFFF, 0, 0, "mult_max");
    endtask

    task automatic test_div();
        run_op(2'b00, 4'b0101, 16'd100, 16'd7, 0, 0, "div");
        run_op(2'b00, 4'b0101, 16'h0055, 16'h0000, 0, 0, "div_zero");
        run_op(2'b00, 4'b0101, 16'hFFFF, 16'h0001, 0, 0, "div_by_one");
        run_op(2'b00, 4'b0101, 16'h0003, 16'hFFFF, 0, 0, "div_small");
    endtask

    task automatic test_abort();
        int seen;
        run_op(2'b00, 4'b0000, 16'h1111, 16'h2222, 0, 0, "pre_abort_add");
        ALUOp = 2'b00; Function = 4'b0100; A = 16'h0005; B = 16'h0007; Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (3) tick();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        n_cmp++;
        if (Ready !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
            n_err++; $display("FAIL abort_idle: Ready=%b Busy=%b Done=%b required 1 0 0", Ready, Busy, Done);
        end
        n_cmp++;
        if (Result !== 16'h3333 || ResultHi !== 16'h0000) begin
            n_err++; $display("FAIL abort_keep: R=%h RH=%h required 3333 0000", Result, ResultHi);
        end
        seen = 0;
        repeat (W + 4) begin tick(); if (Done === 1'b1) seen++; end
        n_cmp++;
        if (seen != 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses required 0", seen); end
        ALUOp = 2'b00; Function = 4'b0001; A = 16'h0009; B = 16'h0004; Start = 1'b1;
        tick();
        Start = 1'b0; Abort = 1'b1;
        tick();
        Abort = 1'b0;
        n_cmp++;
        if (Ready !== 1'b1 || Done !== 1'b0 || Result !== 16'h3333) begin
            n_err++; $display("FAIL abort_exec: Ready=%b Done=%b R=%h required 1 0 3333", Ready, Done, Result);
        end
        run_op(2'b00, 4'b0001, 16'h0009, 16'h0004, 0, 1, "abort_with_start");
    endtask

    task automatic test_random();
        logic [1:0] op; logic [3:0] fn; logic [W-1:0] a, b;
        logic [3:0] fns [4];
        fns[0] = 4'd0; fns[1] = 4'd1; fns[2] = 4'd4; fns[3] = 4'd5;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin op = 2'b00; fn = fns[$urandom_range(0, 3)]; end
            else fn = 4'($urandom);
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 9) == 0) a = '1;
            run_op(op, fn, a, b, 0, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_sub_decode();
        test_mult();
        test_div();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle operation sequencer sitting between the instruction control path and the ALU. It accepts one arithmetic/logic request at a time via a start/ready handshake and decodes `ALUOp`/`Function` into the 3-bit ALU control code. Add, sub, and, or complete in one execute cycle; mult and div run iteratively, one step per clock. It presents registered results with a one-cycle `Done` pulse.

## Interface
- `WIDTH`, 16: operand and result width in bits; must be at least 2.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `Start`  input  1  request valid; accepted only while `Ready`=1.
- `Abort`  input  1  synchronous cancel of the in-flight operation.
- `ALUOp`  input  2  control-path operation class.
- `Function`  input  4  function field.
- `A`  input  WIDTH  operand A; dividend for div.
- `B`  input  WIDTH  operand B; divisor for div.
- `Ready`  output  1  high only in IDLE.
- `Busy`  output  1  high in EXEC and ITER.
- `ALUControl`  output  3  registered decoded code of the accepted operation.
- `Result`  output  WIDTH  sum, difference, logic result, product low word, or quotient.
- `ResultHi`  output  WIDTH  product high word, or remainder; 0 for 1-cycle ops.
- `Done`  output  1  one-cycle pulse; `Result`/`ResultHi` valid from this cycle.
- `DivByZero`  output  1  registered flag; set with `Done` for div with B=0.

## Operation
- **Decode** of {ALUOp,Function} is applied at accept and stored in `ALUControl`:
  - 000000 → 000 add
  - 000001 → 001 sub
  - 000100 → 010 mult
  - 000101 → 011 div
  - 10xxxx → 100 and
  - 11xxxx → 101 or
  - any other encoding → 000 add
- **Accept:** `Start` && `Ready` at a rising edge. Latch A, B and the code; clear `DivByZero`.
  - Code 000/001/100/101 → EXEC.
  - Code 010/011 → ITER with counter = WIDTH.
- **EXEC:** compute the operation, register `Result`, set `ResultHi`=0, go to DONE.
  - Add and sub are unsigned modulo 2^WIDTH; the carry is discarded.
- **ITER, mult:** unsigned shift-add, one partial product per cycle.
  - After WIDTH steps, {ResultHi,Result} = A*B (full 2·WIDTH bits).
- **ITER, div:** unsigned restoring division, one quotient bit per cycle. `Result` = A/B, `ResultHi` = A%B.
- **Divide by zero:** if B=0 at accept, skip ITER and go through EXEC. Result = all-ones, ResultHi = A, DivByZero = 1.
- **ITER counter:** decrements each cycle; the step taken when counter=1 is the last, then the block goes to DONE.
- **DONE:** `Done`=1 for exactly one cycle, then IDLE.
  - `Result`, `ResultHi`, `ALUControl`, `DivByZero` hold until the next accept.
- **Not accepted:** `Start` while `Ready`=0 is ignored and not queued.
- **Abort** in EXEC or ITER → IDLE at the next edge. No `Done` pulse; `Result`/`ResultHi` keep their values from the last completed operation. `Abort` in IDLE or DONE has no effect. If `Abort` and `Start` are both high in IDLE, the `Start` is accepted.
- **Reset** (any time, including mid-ITER): state IDLE, Ready=1, Busy=0, Done=0, ALUControl=000, Result=0, ResultHi=0, DivByZero=0, counter=0.

## Timing
- Accept at edge 0.
- 1-cycle ops and divide-by-zero: `Done` high after edge 1 → latency 1 cycle. Next accept is possible at edge 2.
- Mult/div: `Done` high after edge WIDTH → latency WIDTH cycles; next accept at edge WIDTH+1.
- `Ready`, `Busy` and `Done` are decoded from registered state; `Result`/`ResultHi` are registered.
- No combinational path from inputs to outputs.

## Configuration
- **`ALU_SEQ_DIVIDE_EN` defined:** divider hardware is present and div behaves as specified above.
- **`ALU_SEQ_DIVIDE_EN` undefined:** no divider logic is built. Code 011 goes through EXEC with Result=0, ResultHi=0, DivByZero=0. `ALUControl` still reports 011. Mult is unaffected.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-mult (counter=5) → all outputs take their reset values immediately. After release, `Ready`=1 and no `Done` appears.
- **Add, then or back-to-back:**
  - {00,0000}, A=0x1234, B=0x0FFF → `Done` one cycle after accept, Result=0x2233, ALUControl=000.
  - Immediate `Start` at the next legal edge with {11,xxxx}, A=0x00F0, B=0x0F00 → Result=0x0FF0.
- **Sub wrap and undefined encoding:**
  - {00,0001}, A=0x0000, B=0x0001 → Result=0xFFFF.
  - {01,0011} → ALUControl=000 (add).
- **Mult:** {00,0100}, A=0x0100, B=0x0300 → `Done` 16 cycles after accept, Result=0x0000, ResultHi=0x0003. `Start` during ITER is ignored.
- **Div and divide by zero:**
  - A=100, B=7 → Result=14, ResultHi=2 after 16 cycles.
  - A=0x0055, B=0 → one cycle: Result=0xFFFF, ResultHi=0x0055, DivByZero=1.
  - With the macro undefined: A=100, B=7 → Result=0, ResultHi=0, DivByZero=0 after one cycle.
- **Abort:** assert `Abort` on the 4th ITER cycle of a mult → IDLE next edge, no `Done`, Result/ResultHi keep their prior values.
